volatility_feed_sequencer: RTL and testbench

- Write-side initiator for the per-stock rolling price window.
- Accepts top-of-book updates (best bid/ask, stock id) from the order-book side through a valid/ready handshake, queues them in a small FIFO, and fixes one-sided quotes.
- Keeps a per-stock circular write pointer and fill count, and issues flat-address window writes (valid, address, bid, ask, stock id) to the volatility memory.
- Also runs a per-stock flush that zero-writes a stock's whole window so its moving sums return to 0.

---
 rtl/volatility_feed_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_volatility_feed_sequencer.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/volatility_feed_sequencer.sv
// volatility_feed_sequencer
//   Write-side initiator for the per-stock rolling price window. Queues
//   top-of-book updates in a small FIFO and repairs one-sided quotes.
//   Issues flat-address window writes at {stock, ptr[stock]}. A per-stock
//   flush zero-writes the whole window of one stock.
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_valid/o_ready             update handshake; i_stock_id, i_best_bid,
//                               i_best_ask carry the update
//   i_flush, i_flush_stock_id   single-cycle flush request and its stock
//   i_stall                     downstream cannot take a write this cycle
//   o_valid, o_write_address,   registered window write
//   o_stock_id, o_best_bid,
//   o_best_ask
//   o_buffer_full               per-stock window-filled flags
//   o_flush_busy                flush in progress
// Optional feature: define PRICE_DEDUP_EN to discard popped updates whose
//   mid price repeats the last mid issued for that stock.
module volatility_feed_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int BUFFER_SIZE = 32,
  parameter int NUM_STOCKS  = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset_n,
  input  logic                                        i_valid,
  output logic                                        o_ready,
  input  logic [$clog2(NUM_STOCKS)-1:0]               i_stock_id,
  input  logic [DATA_WIDTH-1:0]                       i_best_bid,
  input  logic [DATA_WIDTH-1:0]                       i_best_ask,
  input  logic                                        i_flush,
  input  logic [$clog2(NUM_STOCKS)-1:0]               i_flush_stock_id,
  input  logic                                        i_stall,
  output logic                                        o_valid,
  output logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0]   o_write_address,
  output logic [$clog2(NUM_STOCKS)-1:0]               o_stock_id,
  output logic [DATA_WIDTH-1:0]                       o_best_bid,
  output logic [DATA_WIDTH-1:0]                       o_best_ask,
  output logic [NUM_STOCKS-1:0]                       o_buffer_full,
  output logic                                        o_flush_busy
);
  localparam int SW = $clog2(NUM_STOCKS);
  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] WIN_SIZE  = (PW+1)'(BUFFER_SIZE);
  localparam logic [PW:0] WIN_LAST  = (PW+1)'(BUFFER_SIZE - 1);
  localparam logic [FW:0] FIFO_FULL = (FW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {IDLE, FLUSH} state_t;
  state_t state, state_next;

  logic [SW-1:0]         q_stock [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_bid   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_ask   [FIFO_DEPTH];
  logic [FW-1:0]         q_wr, q_rd;
  logic [FW:0]           q_cnt, q_cnt_next;

  logic [PW-1:0]         wptr [NUM_STOCKS];
  logic [PW:0]           fill [NUM_STOCKS];

  logic [SW-1:0]         flush_stock;
  logic [PW:0]           flush_idx;

  logic                  advance, push, pop;
  logic                  write_head, write_zero, out_idle;
  logic                  flush_start, flush_end, head_dup;
  logic [DATA_WIDTH-1:0] fix_bid, fix_ask;
  logic [SW-1:0]         head_stock;

  assign advance    = !o_valid || !i_stall;
  // An update with both sides empty is handshaken but never queued.
  assign push       = i_valid && o_ready && (i_best_bid != '0 || i_best_ask != '0);
  assign fix_bid    = (i_best_bid == '0) ? i_best_ask : i_best_bid;
  assign fix_ask    = (i_best_ask == '0) ? i_best_bid : i_best_ask;
  assign head_stock = q_stock[q_rd];

`ifdef PRICE_DEDUP_EN
  logic [DATA_WIDTH:0] last_mid [NUM_STOCKS];
  logic [DATA_WIDTH:0] head_sum, head_mid;
  assign head_sum = {1'b0, q_bid[q_rd]} + {1'b0, q_ask[q_rd]};
  assign head_mid = head_sum >> 1;
  // Queued quotes have both sides non-zero, so a real mid is never 0 and a
  // cleared last_mid can never match: the first update always writes.
  assign head_dup = (head_mid == last_mid[head_stock]);
`else
  assign head_dup = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    write_head  = 1'b0;
    write_zero  = 1'b0;
    out_idle    = 1'b0;
    flush_start = 1'b0;
    flush_end   = 1'b0;
    case (state)
      IDLE: begin
        // A flush request wins over a pending pop; the pop waits.
        if (i_flush) begin
          state_next  = FLUSH;
          flush_start = 1'b1;
          out_idle    = advance;
        end else if (advance) begin
          if (q_cnt != '0) begin
            pop        = 1'b1;
            write_head = !head_dup;
            out_idle   = head_dup;
          end else begin
            out_idle   = 1'b1;
          end
        end
      end
      FLUSH: begin
        // flush_idx reaches WIN_SIZE once the last zero write is presented;
        // the window state is cleared one cycle later.
        if (flush_idx == WIN_SIZE) begin
          state_next = IDLE;
          flush_end  = 1'b1;
          out_idle   = advance;
        end else if (advance) begin
          write_zero = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    q_cnt_next = q_cnt;
    if (push && !pop)      q_cnt_next = q_cnt + 1'b1;
    else if (pop && !push) q_cnt_next = q_cnt - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      q_stock[q_wr] <= i_stock_id;
      q_bid[q_wr]   <= fix_bid;
      q_ask[q_wr]   <= fix_ask;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      q_wr            <= '0;
      q_rd            <= '0;
      q_cnt           <= '0;
      o_ready         <= 1'b0;
      o_valid         <= 1'b0;
      o_write_address <= '0;
      o_stock_id      <= '0;
      o_best_bid      <= '0;
      o_best_ask      <= '0;
      o_buffer_full   <= '0;
      o_flush_busy    <= 1'b0;
      flush_stock     <= '0;
      flush_idx       <= '0;
      for (int unsigned i = 0; i < NUM_STOCKS; i++) begin
        wptr[i] <= '0;
        fill[i] <= '0;
`ifdef PRICE_DEDUP_EN
        last_mid[i] <= '0;
`endif
      end
    end else begin
      q_cnt   <= q_cnt_next;
      o_ready <= (q_cnt_next != FIFO_FULL);
      if (push) q_wr <= q_wr + 1'b1;
      if (pop)  q_rd <= q_rd + 1'b1;

      if (out_idle) o_valid <= 1'b0;

      if (write_head) begin
        o_valid          <= 1'b1;
        o_stock_id       <= head_stock;
        o_write_address  <= {head_stock, wptr[head_stock]};
        o_best_bid       <= q_bid[q_rd];
        o_best_ask       <= q_ask[q_rd];
        wptr[head_stock] <= wptr[head_stock] + 1'b1;
        if (fill[head_stock] != WIN_SIZE) fill[head_stock] <= fill[head_stock] + 1'b1;
        if (fill[head_stock] >= WIN_LAST) o_buffer_full[head_stock] <= 1'b1;
`ifdef PRICE_DEDUP_EN
        last_mid[head_stock] <= head_mid;
`endif
      end

      if (write_zero) begin
        o_valid         <= 1'b1;
        o_stock_id      <= flush_stock;
        o_write_address <= {flush_stock, flush_idx[PW-1:0]};
        o_best_bid      <= '0;
        o_best_ask      <= '0;
        flush_idx       <= flush_idx + 1'b1;
      end

      if (flush_start) begin
        flush_stock  <= i_flush_stock_id;
        flush_idx    <= '0;
        o_flush_busy <= 1'b1;
      end

      if (flush_end) begin
        wptr[flush_stock]          <= '0;
        fill[flush_stock]          <= '0;
        o_buffer_full[flush_stock] <= 1'b0;
        o_flush_busy               <= 1'b0;
`ifdef PRICE_DEDUP_EN
        last_mid[flush_stock] <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_volatility_feed_sequencer.sv
`timescale 1ns/1ps
module tb_volatility_feed_sequencer;
  localparam int DW = 32;
  localparam int BS = 32;
  localparam int NS = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [1:0]    i_stock_id = '0;
  logic [DW-1:0] i_best_bid = '0;
  logic [DW-1:0] i_best_ask = '0;
  logic          i_flush = 1'b0;
  logic [1:0]    i_flush_stock_id = '0;
  logic          i_stall = 1'b0;
  logic          o_valid;
  logic [6:0]    o_write_address;
  logic [1:0]    o_stock_id;
  logic [DW-1:0] o_best_bid;
  logic [DW-1:0] o_best_ask;
  logic [NS-1:0] o_buffer_full;
  logic          o_flush_busy;

  always #5 clk = ~clk;

  volatility_feed_sequencer #(
    .DATA_WIDTH(DW), .BUFFER_SIZE(BS), .NUM_STOCKS(NS), .FIFO_DEPTH(FD)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_stock_id(i_stock_id), .i_best_bid(i_best_bid), .i_best_ask(i_best_ask),
    .i_flush(i_flush), .i_flush_stock_id(i_flush_stock_id), .i_stall(i_stall),
    .o_valid(o_valid), .o_write_address(o_write_address), .o_stock_id(o_stock_id),
    .o_best_bid(o_best_bid), .o_best_ask(o_best_ask),
    .o_buffer_full(o_buffer_full), .o_flush_busy(o_flush_busy)
  );

  typedef struct packed {
    logic [6:0]    addr;
    logic [1:0]    stock;
    logic [DW-1:0] bid;
    logic [DW-1:0] ask;
    logic [NS-1:0] full;
    logic          busy;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference window state: one entry per stock.
  int            m_ptr  [NS];
  int            m_cnt  [NS];
  logic [DW:0]   m_mid  [NS];
  bit            m_have [NS];

  bit   stall_rand = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_stall = 1'b0;

  // Capture each newly presented write once (a stalled write is held).
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (o_valid && !(prev_valid && prev_stall))
        obs_q.push_back(wr_t'{o_write_address, o_stock_id, o_best_bid, o_best_ask,
                              o_buffer_full, o_flush_busy});
      prev_valid = o_valid;
      prev_stall = i_stall;
    end
  end

  always @(posedge clk) begin
    if (stall_rand) begin
      #1;
      i_stall = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_ptr[i] = 0; m_cnt[i] = 0; m_mid[i] = '0; m_have[i] = 1'b0;
    end
    exp_q.delete();
  endfunction

  function automatic logic [NS-1:0] model_full();
    logic [NS-1:0] f;
    for (int i = 0; i < NS; i++) f[i] = (m_cnt[i] >= BS);
    return f;
  endfunction

  function automatic void model_push(input int s, input logic [DW-1:0] b_in, input logic [DW-1:0] a_in);
    logic [DW-1:0] b, a;
    wr_t e;
    b = b_in; a = a_in;
    if (b == 0 && a == 0) return;
    if (b == 0) b = a;
    if (a == 0) a = b;
`ifdef PRICE_DEDUP_EN
    begin
      logic [DW:0] mid;
      mid = ({1'b0, b} + {1'b0, a}) / 2;
      if (m_have[s] && m_mid[s] == mid) return;
      m_have[s] = 1'b1;
      m_mid[s]  = mid;
    end
`endif
    e.addr  = 7'(s * BS + m_ptr[s]);
    e.stock = 2'(s);
    e.bid   = b;
    e.ask   = a;
    m_ptr[s] = (m_ptr[s] + 1) % BS;
    if (m_cnt[s] < BS) m_cnt[s]++;
    e.full = model_full();
    e.busy = 1'b0;
    exp_q.push_back(e);
  endfunction

  function automatic void model_flush(input int s);
    wr_t e;
    for (int k = 0; k < BS; k++) begin
      e.addr = 7'(s * BS + k); e.stock = 2'(s); e.bid = '0; e.ask = '0;
      e.full = model_full(); e.busy = 1'b1;
      exp_q.push_back(e);
    end
    m_ptr[s] = 0; m_cnt[s] = 0; m_have[s] = 1'b0; m_mid[s] = '0;
  endfunction

  // Offer one update (called at posedge+1); returns after acceptance.
  task automatic push(input int s, input logic [DW-1:0] b, input logic [DW-1:0] a);
    int  n = 0;
    bit  ok = 1'b0;
    i_valid = 1'b1; i_stock_id = 2'(s); i_best_bid = b; i_best_ask = a;
    do begin
      @(negedge clk); ok = o_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    i_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL push_accept: o_ready stayed 0 for stock %0d, required 1 within 200 cycles", s);
    end else begin
      model_push(s, b, a);
    end
  endtask

  // Wait until the expected writes have been observed, then idle a little.
  task automatic drain();
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 4000) begin
      @(posedge clk); #1; n++;
    end
    stall_rand = 1'b0;
    @(posedge clk); #1;
    i_stall = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_flush_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b ready=%b busy=%b, required 0 0 0", o_valid, o_ready, o_flush_busy);
    end
    checks++;
    if (o_buffer_full !== '0 || o_write_address !== '0 || o_best_bid !== '0 || o_best_ask !== '0 || o_stock_id !== '0) begin
      errors++;
      $display("FAIL reset_data: full=%b addr=%0d bid=%0d ask=%0d stock=%0d, required all 0",
               o_buffer_full, o_write_address, o_best_bid, o_best_ask, o_stock_id);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: o_ready=%b one cycle after release, required 1", o_ready);
    end
  endtask

  task automatic test_latency();
    wr_t e, o;
    i_stall = 1'b0;
    i_valid = 1'b1; i_stock_id = 2'd1; i_best_bid = 100; i_best_ask = 102;
    @(posedge clk); #1;
    i_valid = 1'b0;
    model_push(1, 100, 102);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: o_valid=%b one cycle after push, required 0", o_valid);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_write_address !== 7'd32 || o_best_bid !== 100 || o_best_ask !== 102) begin
      errors++;
      $display("FAIL latency_write: valid=%b addr=%0d bid=%0d ask=%0d, required 1 32 100 102",
               o_valid, o_write_address, o_best_bid, o_best_ask);
    end
    @(posedge clk); #1;
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL latency_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL latency_data: got addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b, required addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b",
                 o.addr, o.stock, o.bid, o.ask, o.full, o.busy, e.addr, e.stock, e.bid, e.ask, e.full, e.busy);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_fixup();
    wr_t e, o;
    logic [DW-1:0] b, a;
    push(2, 0, 50);
    push(2, 0, 0);
    push(2, 77, 0);
    stall_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(1, 100000));
      a = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(1, 100000));
      push($urandom_range(0, 2), b, a);
    end
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL fixup_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL fixup_data: got addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b, required addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b",
                 o.addr, o.stock, o.bid, o.ask, o.full, o.busy, e.addr, e.stock, e.bid, e.ask, e.full, e.busy);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wrap();
    wr_t e, o;
    stall_rand = 1'b1;
    for (int i = 0; i < 40; i++)
      push(3, DW'(1000 + 3 * i), DW'(2000 + 5 * i));
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wrap_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_data: got addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b, required addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b",
                 o.addr, o.stock, o.bid, o.ask, o.full, o.busy, e.addr, e.stock, e.bid, e.ask, e.full, e.busy);
      end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (o_buffer_full[3] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_full: o_buffer_full[3]=%b after 40 writes, required 1", o_buffer_full[3]);
    end
  endtask

  task automatic test_back_to_back();
    wr_t e, o;
    logic [6:0]    h_addr;
    logic [DW-1:0] h_bid, h_ask;
    stall_rand = 1'b0;
    i_stall = 1'b1;
    for (int i = 0; i < 5; i++) push(i % NS, DW'(500 + 2 * i), DW'(600 + 2 * i));
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_full: ready=%b valid=%b with 4 queued, required 0 1", o_ready, o_valid);
    end
    h_addr = o_write_address; h_bid = o_best_bid; h_ask = o_best_ask;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_write_address !== h_addr || o_best_bid !== h_bid || o_best_ask !== h_ask) begin
        errors++;
        $display("FAIL stall_hold: valid=%b addr=%0d bid=%0d ask=%0d, required 1 %0d %0d %0d",
                 o_valid, o_write_address, o_best_bid, o_best_ask, h_addr, h_bid, h_ask);
      end
    end
    @(posedge clk); #1;
    i_stall = 1'b0;
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stall_data: got addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b, required addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b",
                 o.addr, o.stock, o.bid, o.ask, o.full, o.busy, e.addr, e.stock, e.bid, e.ask, e.full, e.busy);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_flush();
    wr_t e, o;
    for (int i = 0; i < 10; i++) push(0, DW'(40 + i), DW'(60 + i));
    drain();
    i_flush = 1'b1; i_flush_stock_id = 2'd0;
    model_flush(0);
    @(posedge clk); #1;
    i_flush = 1'b0;
    @(negedge clk);
    checks++;
    if (o_flush_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy: o_flush_busy=%b after request, required 1", o_flush_busy);
    end
    @(posedge clk); #1;
    stall_rand = 1'b1;
    push(0, 900, 910);
    i_flush = 1'b1; i_flush_stock_id = 2'd1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    push(0, 920, 930);
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL flush_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL flush_data: got addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b, required addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b",
                 o.addr, o.stock, o.bid, o.ask, o.full, o.busy, e.addr, e.stock, e.bid, e.ask, e.full, e.busy);
      end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (o_buffer_full[0] !== 1'b0 || o_flush_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_end: full[0]=%b busy=%b, required 0 0", o_buffer_full[0], o_flush_busy);
    end
  endtask

  task automatic test_random();
    wr_t e, o;
    logic [DW-1:0] b, a;
    for (int round = 0; round < 2; round++) begin
      if (round == 1) begin
        i_flush = 1'b1; i_flush_stock_id = 2'($urandom_range(0, NS - 1));
        model_flush(int'(i_flush_stock_id));
        @(posedge clk); #1;
        i_flush = 1'b0;
      end
      stall_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
        b = DW'($urandom_range(0, 4));
        a = DW'($urandom_range(0, 4));
        push($urandom_range(0, NS - 1), b, a);
      end
      drain();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL random_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL random_data: got addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b, required addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b",
                   o.addr, o.stock, o.bid, o.ask, o.full, o.busy, e.addr, e.stock, e.bid, e.ask, e.full, e.busy);
        end
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_flush();
    wr_t e, o;
    int n = 0;
    stall_rand = 1'b0; i_stall = 1'b0;
    obs_q.delete();
    i_flush = 1'b1; i_flush_stock_id = 2'd2;
    @(posedge clk); #1;
    i_flush = 1'b0;
    while (obs_q.size() < 8 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (obs_q.size() < 8 || obs_q[7].addr !== 7'd71 || obs_q[7].busy !== 1'b1) begin
      errors++;
      $display("FAIL midflush_progress: %0d zero writes seen, required 8 ending at address 71", obs_q.size());
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_flush_busy !== 1'b0 || o_ready !== 1'b0 || o_buffer_full !== '0) begin
      errors++;
      $display("FAIL midflush_reset: valid=%b busy=%b ready=%b full=%b, required 0 0 0 0",
               o_valid, o_flush_busy, o_ready, o_buffer_full);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    obs_q.delete();
    push(2, 10, 20);
    push(0, 30, 40);
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midflush_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midflush_data: got addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b, required addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b",
                 o.addr, o.stock, o.bid, o.ask, o.full, o.busy, e.addr, e.stock, e.bid, e.ask, e.full, e.busy);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_dedup();
    wr_t e, o;
    push(1, 200, 300);
    push(1, 200, 300);
    push(1, 300, 200);
    push(1, 201, 300);
    push(1, 203, 300);
    push(2, 200, 300);
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL dedup_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL dedup_data: got addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b, required addr=%0d stock=%0d bid=%0d ask=%0d full=%b busy=%b",
                 o.addr, o.stock, o.bid, o.ask, o.full, o.busy, e.addr, e.stock, e.bid, e.ask, e.full, e.busy);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_fixup();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid_flush();
    test_dedup();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
